// File: rtl/hex_glyph_scanner.sv
// Streams a DIGITS-wide hex value as row-major 3x5 glyph pixels over a valid/ready link,
// with leading-zero blanking and per-digit blinking driven by a frame-count phase.
module hex_glyph_scanner #(
  parameter int DIGITS       = 2,
  parameter int GAP          = 1,
  parameter int BLINK_FRAMES = 4,
  localparam int W  = DIGITS * 3 + (DIGITS - 1) * GAP,
  localparam int XW = $clog2(W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  busy,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_data,
  output logic [XW-1:0]         pix_x,
  output logic [2:0]            pix_y,
  output logic                  sof,
  output logic                  eol,
  output logic                  frame_done
);

  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   hide_q;
  logic                phase;
  logic [CW-1:0]       frame_cnt;

  logic [DIGITS-1:0]   lz_mask;
  logic [DIGITS-1:0]   load_hide;
  logic                seen;
  logic                last_col;
  logic [XW-1:0]       nx;
  logic [2:0]          ny;

  // Row r, column c of a glyph lives at bit 12-3r+c
  function automatic logic [14:0] font(input logic [3:0] n);
    logic [14:0] g;
    case (n)
      4'h0: g = 15'h7B6F;
      4'h1: g = 15'h4924;
      4'h2: g = 15'h79CF;
      4'h3: g = 15'h79E7;
      4'h4: g = 15'h5BE4;
      4'h5: g = 15'h73E7;
      4'h6: g = 15'h73EF;
      4'h7: g = 15'h7924;
      4'h8: g = 15'h7BEF;
      4'h9: g = 15'h7BE7;
      4'hA: g = 15'h7BED;
      4'hB: g = 15'h3AEB;
      4'hC: g = 15'h724F;
      4'hD: g = 15'h3B6B;
      4'hE: g = 15'h73CF;
      default: g = 15'h73C9;
    endcase
    return g;
  endfunction

  function automatic logic pixel_of(input logic [4*DIGITS-1:0] val,
                                    input logic [DIGITS-1:0] hide,
                                    input int x, input int y);
    logic       px;
    logic [3:0] nib;
    int         d;
    int         col;
    px  = 1'b0;
    nib = 4'd0;
    d   = 0;
    col = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (x >= k * (3 + GAP) && x < k * (3 + GAP) + 3) begin
        d   = DIGITS - 1 - k;
        col = x - k * (3 + GAP);
        nib = 4'(val >> (4 * d));
        if (1'(hide >> d) == 1'b0)
          px = 1'(font(nib) >> (12 - 3 * y + col));
      end
    end
    return px;
  endfunction

  // Blank every digit above the most significant non-zero one; digit 0 always shows
  always_comb begin
    lz_mask = '0;
    seen    = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (4'(value >> (4 * d)) != 4'd0) seen = 1'b1;
      if (blank_lz && !seen) lz_mask = lz_mask | (DIGITS'(1) << d);
    end
  end

  assign load_hide = lz_mask | (blink_mask & {DIGITS{phase}});

  always_comb begin
    last_col = (pix_x == X_LAST);
    nx       = last_col ? '0 : pix_x + XW'(1);
    ny       = last_col ? pix_y + 3'd1 : pix_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      value_q    <= '0;
      hide_q     <= '0;
      phase      <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= 1'b0;
      pix_x      <= '0;
      pix_y      <= 3'd0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state     <= RUN;
            value_q   <= value;
            hide_q    <= load_hide;
            busy      <= 1'b1;
            pix_valid <= 1'b1;
            pix_x     <= '0;
            pix_y     <= 3'd0;
            sof       <= 1'b1;
            eol       <= 1'b0;
            pix_data  <= pixel_of(value, load_hide, 0, 0);
          end
        end
        RUN: begin
          if (pix_ready) begin
            if (last_col && pix_y == 3'd4) begin
              state      <= DONE;
              busy       <= 1'b0;
              pix_valid  <= 1'b0;
              frame_done <= 1'b1;
              pix_data   <= 1'b0;
              pix_x      <= '0;
              pix_y      <= 3'd0;
              sof        <= 1'b0;
              eol        <= 1'b0;
            end else begin
              pix_x    <= nx;
              pix_y    <= ny;
              sof      <= 1'b0;
              eol      <= (nx == X_LAST);
              pix_data <= pixel_of(value_q, hide_q, int'(nx), int'(ny));
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            phase     <= ~phase;
          end else begin
            frame_cnt <= frame_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hex_glyph_scanner.md
Name: hex_glyph_scanner

Overview:
- Parametrised successor to the fixed two-digit hex font lookup.
- Renders a DIGITS-wide hex value as a row-major 1-bit pixel stream of 3x5 glyphs, with configurable inter-digit gap.
- Adds leading-zero blanking and per-digit blinking (internal frame-count phase).
- Sits between the value source and the display framebuffer/LED-matrix writer; uses a valid/ready output handshake.

Parameters:
- DIGITS, 2, number of hex digits rendered (1..8).
- GAP, 1, blank columns between adjacent glyphs (0..3).
- BLINK_FRAMES, 4, completed frames per blink phase toggle (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- value  in  4*DIGITS  hex value; digit DIGITS-1 is leftmost
- load  in  1  start-frame request
- blank_lz  in  1  blank leading zero digits (sampled with load)
- blink_mask  in  DIGITS  per-digit blink enable (sampled with load)
- busy  out  1  frame in progress
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  1  pixel on/off
- pix_x  out  $clog2(W)  column, W = DIGITS*3 + (DIGITS-1)*GAP
- pix_y  out  3  row 0..4, 0 = top
- sof  out  1  high with pixel (0,0)
- eol  out  1  high with pixel x = W-1
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Font: 15-bit glyph per nibble, identical to the display's existing hex font. Row r, column c (0 = left) is bit 12-3r+c.
- Examples: 0 = 15'h7B6F, 1 = 15'h4924, A = 15'h7BED.
- Reset: busy=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, sof=0, eol=0, frame_done=0; blink phase=0; frame counter=0.
- Reset asserted mid-frame abandons the frame; no frame_done is issued.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: load=1 captures value, blank_lz and blink_mask; go to RUN; busy=1 from the next cycle.
  - RUN: pix_valid=1 from the cycle after the load (latency 1), starting at pixel (0,0).
  - DONE: frame_done=1 for one cycle; busy=0 in DONE; return to IDLE.
- load while busy=1 is ignored. Inputs changing during a frame have no effect; all are captured at load.
- Handshake:
  - A pixel transfers when pix_valid & pix_ready.
  - While pix_valid=1 and pix_ready=0, pix_data, pix_x, pix_y, sof and eol hold stable.
  - On transfer, x increments. At x = W-1, x wraps to 0 and y increments.
  - Transfer at (W-1, 4) -> DONE, and pix_valid=0 the next cycle.
- Frame = 5*W pixels, every one emitted, including gaps.
- Pixel value:
  - Gap columns are 0.
  - A glyph column is 0 if its digit is blanked or blinked-off; otherwise it is the font bit.
- Leading-zero blanking: with blank_lz=1, digits left of the most significant non-zero digit are blanked. Digit 0 is never blanked, so value 0 shows a single "0".
- Blink:
  - With phase=1, digits with blink_mask bit set render off.
  - The frame counter increments at each DONE. On reaching BLINK_FRAMES it clears and phase toggles.
  - Phase is captured at load, so it is constant within a frame.
- Minimum frame-to-frame spacing: the last transfer, then DONE, then load accepted in IDLE. pix_valid is low for at least 2 cycles between frames.

Test Plan:
- DIGITS=2, GAP=1, value=8'h10, pix_ready=1 -> 35 pixels.
  - Row 0 = 0,0,1,0,1,1,1; sof on the first pixel; eol every 7th pixel.
  - frame_done pulses once, the cycle after the 35th transfer; busy falls in the same cycle.
- Same frame with pix_ready toggling pseudo-randomly -> identical 35-pixel sequence, outputs held stable during stalls, no pixel dropped or duplicated.
- value=8'h0A, blank_lz=1 -> columns 0-2 all 0 in every row; row 0 right glyph = 1,1,1 ("A"). value=8'h00, blank_lz=1 -> right glyph "0" shown.
- BLINK_FRAMES=2, blink_mask=2'b01, value=8'hAA, 6 back-to-back frames -> right glyph shown in frames 1-2, blank in frames 3-4, shown in frames 5-6; left glyph always shown.
- load asserted during RUN with a different value -> ignored; frame completes with the original value.
- rst asserted at pixel 10 -> next cycle busy=0, pix_valid=0, no frame_done. A new load then restarts at (0,0) with sof=1.
